serial_adder: RTL

Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit dataflow full adder. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first. A registered carry chains the digits between cycles, and a start/busy/done handshake frames each operation. It gives datapath blocks an area-cheap add/sub when latency is not critical.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_digit_adder.sv | 27 ++
 rtl/serial_adder.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared encodings and sizing helpers for the serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  // Number of digit steps needed to cover a full operand.
  function automatic int num_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Step-counter width; never narrower than one bit.
  function automatic int step_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive two's-complement overflow on the final digit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  // Ripple of full-adder equations, one per bit.
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB digit first, framed by a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NUM_STEPS = num_steps(WIDTH, DIGIT);
  localparam int STEP_W    = step_width(NUM_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t            state, state_next;
  logic [STEP_W-1:0] cnt;
  logic [WIDTH-1:0]  a_sh, b_sh, res_sh, res_next;
  logic              cy;
  logic              load, step, last;

  logic [DIGIT-1:0]  d_s;
  logic              d_cout, d_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (a_sh[DIGIT-1:0]),
    .y        (b_sh[DIGIT-1:0]),
    .cin      (cy),
    .s        (d_s),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  // New digit enters the result register from the top; oldest bits drop off.
  assign res_next = WIDTH'({d_s, res_sh} >> DIGIT);

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == LAST_STEP) begin
          last       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Operand capture, digit stepping and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cy       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        a_sh <= a;
        b_sh <= sub ? ~b : b;
        cy   <= sub ? 1'b1 : c_in;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (step) begin
        a_sh   <= a_sh >> DIGIT;
        b_sh   <= b_sh >> DIGIT;
        res_sh <= res_next;
        cy     <= d_cout;
        cnt    <= cnt + STEP_W'(1);
        if (last) begin
          sum      <= res_next;
          carry    <= d_cout;
          overflow <= d_cmsb ^ d_cout;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule
